keypad_entry_ctrl: RTL

//   Sequencer for the keypad adder: scans the 4x4 keypad, debounces keys and collects BCD digits

---
 rtl/suma_pkg.sv | 19 +
 rtl/keypad_scan.sv | 90 +++++++++
 rtl/keypad_entry_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/suma_pkg.sv
// suma_pkg: shared types and constants for the keypad adder entry path
package suma_pkg;
   typedef enum logic [1:0] {S_A, S_B, S_SUM, S_RES} state_t;
   typedef logic [3:0] key_t;
   localparam key_t KEY_STAR = 4'hE;
   localparam key_t KEY_HASH = 4'hF;
   localparam logic [1:0] DISP_A   = 2'b00;
   localparam logic [1:0] DISP_B   = 2'b01;
   localparam logic [1:0] DISP_RES = 2'b10;
   localparam key_t KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };
   function automatic logic is_digit(key_t k);
      return k <= 4'd9;
   endfunction
endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: drives keypad rows, samples columns and debounces them into one-shot key events
module keypad_scan
   import suma_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] fila,
   output logic       key_valid,
   output key_t       key_code
);
   localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int RW = $clog2(4 * DEBOUNCE_SCANS + 1);
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    row_q, row_d, cand_row_q, cand_row_d, cidx;
   logic [3:0]    c1_q, c2_q;
   key_t          cand_q, cand_d, code_q, code_d, code;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] idle_q, idle_d;
   logic          held_q, held_d, valid_q, valid_d, sample, hit;
   always_comb begin
      sample = div_q == DW'(SCAN_DIV - 1);
      div_d = sample ? '0 : div_q + DW'(1);
      row_d = sample ? row_q + 2'd1 : row_q;
      hit = $countones(c2_q) == 1;
      cidx = c2_q[3] ? 2'd0 : c2_q[2] ? 2'd1 : c2_q[1] ? 2'd2 : 2'd3;
      code = KEYMAP[row_q][cidx];
      cand_d = cand_q;
      cand_row_d = cand_row_q;
      cnt_d = cnt_q;
      idle_d = idle_q;
      held_d = held_q;
      code_d = code_q;
      valid_d = 1'b0;
      if (sample && hit) begin
         idle_d = '0;
         if (cnt_q != '0 && code == cand_q)
            cnt_d = cnt_q == CW'(DEBOUNCE_SCANS) ? cnt_q : cnt_q + CW'(1);
         else begin
            cand_d = code;
            cand_row_d = row_q;
            cnt_d = CW'(1);
         end
         if (cnt_d == CW'(DEBOUNCE_SCANS) && !held_q) begin
            valid_d = 1'b1;
            held_d = 1'b1;
            code_d = cand_d;
         end
      end else if (sample) begin
         if (row_q == cand_row_q) cnt_d = '0;
         idle_d = idle_q == RW'(4 * DEBOUNCE_SCANS) ? idle_q : idle_q + RW'(1);
         // release only after DEBOUNCE_SCANS whole scans came back empty
         if (idle_d == RW'(4 * DEBOUNCE_SCANS)) held_d = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         row_q <= '0;
         c1_q <= '0;
         c2_q <= '0;
         cand_q <= '0;
         cand_row_q <= '0;
         cnt_q <= '0;
         idle_q <= '0;
         held_q <= 1'b0;
         code_q <= '0;
         valid_q <= 1'b0;
      end else begin
         div_q <= div_d;
         row_q <= row_d;
         c1_q <= col;
         c2_q <= c1_q;
         cand_q <= cand_d;
         cand_row_q <= cand_row_d;
         cnt_q <= cnt_d;
         idle_q <= idle_d;
         held_q <= held_d;
         code_q <= code_d;
         valid_q <= valid_d;
      end
   end
   assign fila = 4'b0001 << row_q;
   assign key_valid = valid_q;
   assign key_code = code_q;
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: collects BCD operands from the keypad and sequences the adder start and display select
module keypad_entry_ctrl
   import suma_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int NDIG           = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        col,
   input  logic              operador,
   output logic [3:0]        fila,
   output logic [4*NDIG-1:0] num_a,
   output logic [4*NDIG-1:0] num_b,
   output logic              suma_go,
   output logic [1:0]        disp_sel,
   output logic [1:0]        digit_cnt
);
   localparam int W = 4 * NDIG;
   logic         key_valid, op_evt, dig, star;
   key_t         key_code;
   state_t       state_q, state_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, cur, ent;
   logic [1:0]   cnt_q, cnt_d, ent_cnt, disp_q, disp_d;
   logic [2:0]   op_q, op_d;
   logic         go_q, go_d;
   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_scan (
      .clk(clk), .rst(rst), .col(col), .fila(fila), .key_valid(key_valid), .key_code(key_code)
   );
   always_comb begin
      op_d = {op_q[1:0], operador};
      op_evt = op_q[1] & ~op_q[2];
      dig = key_valid && is_digit(key_code);
      star = key_valid && key_code == KEY_STAR;
      cur = state_q == S_B ? b_q : a_q;
      ent = cur;
      ent_cnt = cnt_q;
      if (dig && cnt_q < 2'(NDIG)) begin
         ent = W'({cur, key_code});
         ent_cnt = cnt_q + 2'd1;
      end else if (star) begin
         ent = '0;
         ent_cnt = '0;
      end
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      cnt_d = cnt_q;
      disp_d = disp_q;
      go_d = 1'b0;
      // op_evt takes priority, so a key landing in the same cycle is dropped
      case (state_q)
         S_A:
            if (op_evt) begin
               state_d = S_B;
               cnt_d = '0;
               disp_d = DISP_B;
            end else begin
               a_d = ent;
               cnt_d = ent_cnt;
            end
         S_B:
            if (op_evt) begin
               state_d = S_SUM;
               go_d = 1'b1;
               disp_d = DISP_RES;
            end else begin
               b_d = ent;
               cnt_d = ent_cnt;
            end
         S_SUM: state_d = S_RES;
         S_RES:
            if (op_evt || (key_valid && key_code == KEY_HASH)) begin
               state_d = S_A;
               a_d = '0;
               b_d = '0;
               cnt_d = '0;
               disp_d = DISP_A;
            end else if (dig) begin
               state_d = S_A;
               a_d = W'(key_code);
               b_d = '0;
               cnt_d = 2'd1;
               disp_d = DISP_A;
            end
         default: state_d = S_A;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_A;
         a_q <= '0;
         b_q <= '0;
         cnt_q <= '0;
         disp_q <= DISP_A;
         go_q <= 1'b0;
         op_q <= '0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         cnt_q <= cnt_d;
         disp_q <= disp_d;
         go_q <= go_d;
         op_q <= op_d;
      end
   end
   assign num_a = a_q;
   assign num_b = b_q;
   assign suma_go = go_q;
   assign disp_sel = disp_q;
   assign digit_cnt = cnt_q;
endmodule
